// File: rtl/rtc_bus_arbiter.sv
// ============================================================================
// Module      : rtc_bus_arbiter
// Description : Five-requester bus arbiter for the RTC transaction engine with
//               fixed priority, read anti-starvation, timeout and idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_bus_arbiter #(
    parameter int TIMEOUT = 1000,
    parameter int GAP     = 4,
    parameter int STARVE  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] req,
    input  logic       bus_done,
    output logic [2:0] sel,
    output logic       start,
    output logic [4:0] grant,
    output logic [4:0] ack,
    output logic       busy,
    output logic       err
);

    localparam logic [11:0] c_TO_LAST  = 12'(TIMEOUT - 1);
    localparam logic [3:0]  c_GAP_LAST = 4'(GAP - 1);
    localparam logic [3:0]  c_STARVE   = 4'(STARVE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic        start_q, start_d;
    logic [4:0]  grant_q, grant_d;
    logic [4:0]  ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [11:0] to_cnt_q, to_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [3:0]  starve_q, starve_d;

    logic [4:0]  w_win;
    logic [2:0]  w_code;

    // Winner selection; a starved read overrides the fixed priority order.
    always_comb begin
        w_win  = 5'b00000;
        w_code = 3'd0;
        if (req[4] && (starve_q == c_STARVE)) begin
            w_win  = 5'b10000;
            w_code = 3'd2;
        end else if (req[0]) begin
            w_win  = 5'b00001;
            w_code = 3'd1;
        end else if (req[1]) begin
            w_win  = 5'b00010;
            w_code = 3'd3;
        end else if (req[2]) begin
            w_win  = 5'b00100;
            w_code = 3'd4;
        end else if (req[3]) begin
            w_win  = 5'b01000;
            w_code = 3'd5;
        end else if (req[4]) begin
            w_win  = 5'b10000;
            w_code = 3'd2;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        start_d   = 1'b0;
        grant_d   = grant_q;
        ack_d     = 5'b00000;
        err_d     = 1'b0;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        starve_d  = starve_q;

        case (state_q)
            ST_IDLE: begin
                if (!req[4]) begin
                    starve_d = 4'd0;
                end
                if (|req) begin
                    grant_d = w_win;
                    sel_d   = w_code;
                    start_d = 1'b1;
                    state_d = ST_START;
                    if (w_win[4]) begin
                        starve_d = 4'd0;
                    end else if (req[4]) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            ST_START: begin
                to_cnt_d = 12'd0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                // bus_done is tested first so it wins a same-edge timeout.
                if (bus_done) begin
                    ack_d     = grant_q;
                    grant_d   = 5'b00000;
                    sel_d     = 3'd0;
                    gap_cnt_d = 4'd0;
                    state_d   = ST_GAP;
                end else if (to_cnt_q == c_TO_LAST) begin
                    err_d     = 1'b1;
                    grant_d   = 5'b00000;
                    sel_d     = 3'd0;
                    gap_cnt_d = 4'd0;
                    state_d   = ST_GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 12'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == c_GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 5'b00000;
                sel_d   = 3'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= 3'd0;
            start_q   <= 1'b0;
            grant_q   <= 5'b00000;
            ack_q     <= 5'b00000;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            to_cnt_q  <= 12'd0;
            gap_cnt_q <= 4'd0;
            starve_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            start_q   <= start_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            starve_q  <= starve_d;
        end
    end

    assign sel   = sel_q;
    assign start = start_q;
    assign grant = grant_q;
    assign ack   = ack_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_arbiter.sv
// ============================================================================
// Module      : tb_rtc_bus_arbiter
// Description : Self-checking bench for rtc_bus_arbiter (vector table, corner
//               sequences and randomized traffic against a timestamp model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtc_bus_arbiter;

    localparam int TIMEOUT = 1000;
    localparam int GAP     = 4;
    localparam int STARVE  = 4;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic [4:0] req      = 5'b00000;
    logic       bus_done = 1'b0;
    logic [2:0] sel;
    logic       start;
    logic [4:0] grant;
    logic [4:0] ack;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    rtc_bus_arbiter #(
        .TIMEOUT (TIMEOUT),
        .GAP     (GAP),
        .STARVE  (STARVE)
    ) u_dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .bus_done (bus_done),
        .sel      (sel),
        .start    (start),
        .grant    (grant),
        .ack      (ack),
        .busy     (busy),
        .err      (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] req;
        logic       done;
        logic [2:0] sel;
        logic       start;
        logic [4:0] grant;
        logic [4:0] ack;
        logic       busy;
        logic       err;
    } vec_t;

    // Reference model: a transaction is described by its launch edge and its
    // end edge; every output is derived from those timestamps.
    int n_edge    = 0;
    int m_active  = 0;
    int m_launch  = 0;
    int m_end     = -1;
    int m_next_ok = 0;
    int m_owner   = 0;
    int m_streak  = 0;
    bit m_done    = 1'b0;
    int e_out     = 0;
    int codes [5] = '{1, 3, 4, 5, 2};

    function automatic int pack(input logic [2:0] s, input logic st, input logic [4:0] g,
                                input logic [4:0] a, input logic b, input logic e);
        return int'({s, st, g, a, b, e});
    endfunction

    function automatic int dut_out();
        return int'({sel, start, grant, ack, busy, err});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, n_edge);
        end
    endtask

    task automatic model_reset();
        m_active  = 0;
        m_end     = -1;
        m_next_ok = 0;
        m_streak  = 0;
        e_out     = 0;
    endtask

    task automatic model_edge(input logic [4:0] r, input logic d);
        int w;
        logic [4:0] g_exp;
        logic [4:0] a_exp;
        logic [2:0] s_exp;
        n_edge++;
        if (m_active != 0) begin
            if (n_edge >= m_launch + 2 && (d || n_edge == m_launch + 1 + TIMEOUT)) begin
                m_end     = n_edge;
                m_done    = d;
                m_active  = 0;
                m_next_ok = n_edge + GAP + 1;
            end
        end else if (n_edge >= m_next_ok) begin
            if (!r[4]) m_streak = 0;
            if (r != 5'b00000) begin
                w = 4;
                if (!(r[4] && m_streak == STARVE)) begin
                    for (int i = 4; i >= 0; i--) if (r[i]) w = i;
                end
                if (w == 4) m_streak = 0;
                else if (r[4]) m_streak++;
                m_owner  = w;
                m_launch = n_edge;
                m_active = 1;
            end
        end
        g_exp = (m_active != 0) ? 5'(1 << m_owner) : 5'b00000;
        s_exp = (m_active != 0) ? 3'(codes[m_owner]) : 3'd0;
        a_exp = (m_active == 0 && n_edge == m_end && m_done) ? 5'(1 << m_owner) : 5'b00000;
        e_out = pack(s_exp, (m_active != 0) && n_edge == m_launch, g_exp, a_exp,
                     (m_active != 0) || (n_edge < m_next_ok - 1),
                     (m_active == 0) && n_edge == m_end && !m_done);
    endtask

    task automatic step(input logic [4:0] r, input logic d);
        req      = r;
        bus_done = d;
        @(posedge clock);
        model_edge(r, d);
        #1;
        check("model", dut_out(), e_out);
        check("grant_onehot0", int'($onehot0(grant)), 1);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        req      = 5'b00000;
        bus_done = 1'b0;
        #1;
        check("reset_state", dut_out(), 0);
        model_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       tbl [13];
        int         sq [$];
        int         exp_seq [5] = '{1, 3, 3, 3, 2};
        logic [4:0] r;
        logic       d;
        int         t0, t_err, t_st;
        bit         ack_seen;

        //            req       done  sel   st    grant     ack       busy  err
        tbl[0]  = '{5'b10000, 1'b0, 3'd2, 1'b1, 5'b10000, 5'b00000, 1'b1, 1'b0};
        tbl[1]  = '{5'b00000, 1'b1, 3'd2, 1'b0, 5'b10000, 5'b00000, 1'b1, 1'b0};
        tbl[2]  = '{5'b00000, 1'b0, 3'd2, 1'b0, 5'b10000, 5'b00000, 1'b1, 1'b0};
        tbl[3]  = '{5'b00000, 1'b0, 3'd2, 1'b0, 5'b10000, 5'b00000, 1'b1, 1'b0};
        tbl[4]  = '{5'b00000, 1'b0, 3'd2, 1'b0, 5'b10000, 5'b00000, 1'b1, 1'b0};
        tbl[5]  = '{5'b00000, 1'b1, 3'd0, 1'b0, 5'b00000, 5'b10000, 1'b1, 1'b0};
        tbl[6]  = '{5'b00000, 1'b1, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0};
        tbl[7]  = '{5'b00000, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0};
        tbl[8]  = '{5'b00000, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0};
        tbl[9]  = '{5'b00100, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0};
        tbl[10] = '{5'b00100, 1'b1, 3'd4, 1'b1, 5'b00100, 5'b00000, 1'b1, 1'b0};
        tbl[11] = '{5'b00000, 1'b0, 3'd4, 1'b0, 5'b00100, 5'b00000, 1'b1, 1'b0};
        tbl[12] = '{5'b00000, 1'b0, 3'd4, 1'b0, 5'b00100, 5'b00000, 1'b1, 1'b0};

        #2;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].req, tbl[i].done);
            check($sformatf("vec%0d", i), dut_out(),
                  pack(tbl[i].sel, tbl[i].start, tbl[i].grant, tbl[i].ack, tbl[i].busy, tbl[i].err));
        end

        // All requesters active: init drops after its grant, read forced by starvation.
        do_reset();
        r = 5'b11111;
        for (int i = 0; i < 200 && sq.size() < 5; i++) begin
            step(r, 1'b1);
            if (start) begin
                sq.push_back(int'(sel));
                if (sel == 3'd1) r[0] = 1'b0;
            end
        end
        for (int k = 0; k < 5; k++) begin
            check($sformatf("starve_seq%0d", k), (k < sq.size()) ? sq[k] : -1, exp_seq[k]);
        end

        // Timeout with the requester held.
        do_reset();
        step(5'b00010, 1'b0);
        check("to_first_start", int'(start), 1);
        t0 = n_edge;
        t_err = -1;
        ack_seen = 1'b0;
        for (int i = 0; i < TIMEOUT + 10 && t_err < 0; i++) begin
            step(5'b00010, 1'b0);
            if (ack != 5'b00000) ack_seen = 1'b1;
            if (err) t_err = n_edge;
        end
        check("to_err_latency", t_err - t0, TIMEOUT + 1);
        check("to_no_ack", int'(ack_seen), 0);
        t_st = -1;
        for (int i = 0; i < GAP + 5 && t_st < 0; i++) begin
            step(5'b00010, 1'b0);
            if (start) t_st = n_edge;
        end
        check("to_restart_gap", t_st - t_err, GAP + 1);

        // bus_done on the timeout edge.
        do_reset();
        step(5'b00010, 1'b0);
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            step(5'b00000, (k == TIMEOUT + 1));
        end
        check("collide_ack", int'(ack), int'(5'b00010));
        check("collide_err", int'(err), 0);

        // Asynchronous reset in the middle of WAIT.
        do_reset();
        step(5'b00100, 1'b0);
        step(5'b00100, 1'b0);
        step(5'b00100, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", dut_out(), 0);
        model_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        step(5'b00100, 1'b0);
        check("post_reset_sel", int'(sel), 4);
        check("post_reset_start", int'(start), 1);

        // Randomized traffic, spurious done pulses and occasional resets.
        do_reset();
        r = 5'b00000;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) r = 5'($urandom) & 5'($urandom);
            d = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1499) == 0) do_reset();
            step(r, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
